uart_rx_ctrl: RTL and testbench

- Control and buffering front-end for the UART receiver.
- Drives the receiver's enable and parity-check inputs from a CTRL register.
- Captures each completed frame (dat, ERR, INT) into a DEPTH-entry, 9-bit-wide FIFO.
- Exposes DATA/STATUS/CTRL/CLEAR registers on a simple 2-bit-address peripheral bus and raises one level interrupt to the core.

---
 rtl/uart_rx_ctrl_if.sv | 25 ++
 rtl/uart_rx_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Peripheral register bus between the core (master) and uart_rx_ctrl (slave).
// bus_wr / bus_rd are single-cycle strobes; bus_rdata is registered and valid the cycle after bus_rd.
interface uart_rx_ctrl_if;
  logic [1:0] bus_addr;
  logic       bus_wr;
  logic       bus_rd;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;

  modport master (
    output bus_addr,
    output bus_wr,
    output bus_rd,
    output bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr,
    input  bus_wr,
    input  bus_rd,
    input  bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver control/buffer front-end: CTRL/STATUS/DATA/CLEAR registers, frame FIFO, irq.
// Optional receive-timeout flag is built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_dat,
  input  logic       rx_int,
  input  logic       rx_err,
  output logic       rx_en,
  output logic       rx_chk_en,
  uart_rx_ctrl_if.slave bus,
  output logic       irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("uart_rx_ctrl: DEPTH must be a power of two in 2..16 and TIMEOUT >= 1");
  end

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    ctrl;
  logic [7:0]    rdata_q;
  logic          rx_int_q;
  logic          ovr;
  logic          perr;
  logic          to_flag;
  logic          to_set;
  logic          irq_q;

  logic          push;
  logic          pop;
  logic          push_ok;
  logic          full;
  logic          empty;
  logic          ctrl_wr;
  logic          clr_wr;
  logic          thr_hit;
  logic [8:0]    head;
  logic [7:0]    status;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // Edge detect gives one push per frame no matter how long rx_int is held.
  assign push    = rx_int & ~rx_int_q;
  assign push_ok = push & ~full;
  assign pop     = bus.bus_rd & (bus.bus_addr == ADDR_DATA) & ~empty;
  assign ctrl_wr = bus.bus_wr & (bus.bus_addr == ADDR_CTRL);
  assign clr_wr  = bus.bus_wr & (bus.bus_addr == ADDR_CLEAR);
  assign thr_hit = (8'(count) > {4'h0, ctrl[7:4]});

  always_comb begin
    status    = 8'h00;
    status[0] = ~empty;
    status[1] = full;
    status[2] = ovr;
    status[3] = perr;
    status[4] = empty ? 1'b0 : head[8];
    status[5] = to_flag;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {rx_err, rx_dat};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ctrl     <= 8'h00;
      rdata_q  <= 8'h00;
      rx_int_q <= 1'b0;
      ovr      <= 1'b0;
      perr     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rx_int_q <= rx_int;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Set events take priority over a write-1-to-clear in the same cycle.
      ovr  <= (push & full)   | (ovr  & ~(clr_wr & bus.bus_wdata[2]));
      perr <= (push & rx_err) | (perr & ~(clr_wr & bus.bus_wdata[3]));
      if (ctrl_wr) ctrl <= bus.bus_wdata;
      if (bus.bus_rd) begin
        case (bus.bus_addr)
          ADDR_DATA:   rdata_q <= empty ? 8'h00 : head[7:0];
          ADDR_STATUS: rdata_q <= status;
          ADDR_CTRL:   rdata_q <= ctrl;
          default:     rdata_q <= 8'h00;
        endcase
      end
      irq_q <= (ctrl[2] & thr_hit) | (ctrl[3] & (ovr | perr | to_flag));
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] idle;

  // Fires on the single cycle the idle count steps onto TIMEOUT.
  assign to_set = ~push & ~pop & ~empty & (idle == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle    <= '0;
      to_flag <= 1'b0;
    end else begin
      if (push | pop | empty)      idle <= '0;
      else if (idle != TW'(TIMEOUT)) idle <= idle + TW'(1);
      to_flag <= to_set | (to_flag & ~(clr_wr & bus.bus_wdata[5]));
    end
  end
`else
  assign to_set  = 1'b0;
  assign to_flag = 1'b0;
`endif

  assign rx_en         = ctrl[0];
  assign rx_chk_en     = ctrl[1];
  assign bus.bus_rdata = rdata_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue-level reference model checked every cycle, plus directed literal checks.
module tb_uart_rx_ctrl;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 256;

  logic       clk;
  logic       rst;
  logic [7:0] rx_dat;
  logic       rx_int;
  logic       rx_err;
  logic       rx_en;
  logic       rx_chk_en;
  logic       irq;

  uart_rx_ctrl_if bus_if ();

  uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_dat    (rx_dat),
    .rx_int    (rx_int),
    .rx_err    (rx_err),
    .rx_en     (rx_en),
    .rx_chk_en (rx_chk_en),
    .bus       (bus_if),
    .irq       (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_on = 1'b0;

  // ---------------- reference model ----------------
  logic [8:0] exp_q[$];
  logic [7:0] m_ctrl;
  logic [7:0] m_rdata;
  logic       m_irq, m_ovr, m_perr, m_to, m_prev;
  longint     m_cyc, m_last_act;

  task automatic model_reset();
    exp_q.delete();
    m_ctrl = 8'h00; m_rdata = 8'h00; m_irq = 1'b0;
    m_ovr = 1'b0; m_perr = 1'b0; m_to = 1'b0; m_prev = 1'b0;
    m_last_act = m_cyc;
  endtask

  task automatic model_step();
    int         n;
    bit         is_full, pe, pp, to_hit, irq_n;
    logic [7:0] st;
    m_cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    n       = exp_q.size();
    is_full = (n == DEPTH);
    st      = {2'b00, m_to, (n != 0) ? exp_q[0][8] : 1'b0, m_perr, m_ovr, is_full, n != 0};
    irq_n   = (m_ctrl[2] && n > int'(m_ctrl[7:4])) || (m_ctrl[3] && (m_ovr || m_perr || m_to));
    if (bus_if.bus_rd) begin
      case (bus_if.bus_addr)
        2'd0:    m_rdata = (n != 0) ? exp_q[0][7:0] : 8'h00;
        2'd1:    m_rdata = st;
        2'd2:    m_rdata = m_ctrl;
        default: m_rdata = 8'h00;
      endcase
    end
    pe     = rx_int && !m_prev;
    m_prev = rx_int;
    pp     = bus_if.bus_rd && bus_if.bus_addr == 2'd0 && n != 0;
    to_hit = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
    // Timeout: TIMEOUT cycles since the last push, pop or empty cycle.
    if (pe || pp || n == 0) m_last_act = m_cyc;
    else if (m_cyc - m_last_act == longint'(TIMEOUT)) to_hit = 1'b1;
`endif
    if (pp) void'(exp_q.pop_front());
    if (pe && !is_full) exp_q.push_back({rx_err, rx_dat});
    if (bus_if.bus_wr && bus_if.bus_addr == 2'd3) begin
      if (bus_if.bus_wdata[2]) m_ovr  = 1'b0;
      if (bus_if.bus_wdata[3]) m_perr = 1'b0;
      if (bus_if.bus_wdata[5]) m_to   = 1'b0;
    end
    if (pe && is_full) m_ovr  = 1'b1;
    if (pe && rx_err)  m_perr = 1'b1;
    if (to_hit)        m_to   = 1'b1;
    if (bus_if.bus_wr && bus_if.bus_addr == 2'd2) m_ctrl = bus_if.bus_wdata;
    m_irq = irq_n;
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (cmp_on && !rst) begin
      chk("model_rdata", bus_if.bus_rdata, m_rdata);
      chk("model_irq", {7'b0, irq}, {7'b0, m_irq});
      chk("model_rx_en", {7'b0, rx_en}, {7'b0, m_ctrl[0]});
      chk("model_rx_chk_en", {7'b0, rx_chk_en}, {7'b0, m_ctrl[1]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(logic [1:0] a, logic [7:0] d);
    bus_if.bus_addr = a; bus_if.bus_wdata = d; bus_if.bus_wr = 1'b1;
    tick();
    bus_if.bus_wr = 1'b0;
  endtask

  task automatic read_expect(logic [1:0] a, logic [7:0] e, string name);
    bus_if.bus_addr = a; bus_if.bus_rd = 1'b1;
    tick();
    bus_if.bus_rd = 1'b0;
    chk(name, bus_if.bus_rdata, e);
  endtask

  task automatic frame(logic [7:0] d, logic e, int hold);
    rx_dat = d; rx_err = e; rx_int = 1'b1;
    tick(hold);
    rx_int = 1'b0;
    tick(2);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; rx_dat = 8'h00; rx_int = 1'b0; rx_err = 1'b0;
    bus_if.bus_addr = 2'd0; bus_if.bus_wr = 1'b0; bus_if.bus_rd = 1'b0; bus_if.bus_wdata = 8'h00;
    tick(3);
    chk("rst_rdata", bus_if.bus_rdata, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_rx_en", {7'b0, rx_en}, 8'h00);
    chk("rst_rx_chk_en", {7'b0, rx_chk_en}, 8'h00);
    rst = 1'b0;
    cmp_on = 1'b1;
    tick();

    // Enable receiver and parity check.
    bus_write(2'd2, 8'h03);
    chk("ctrl_rx_en", {7'b0, rx_en}, 8'h01);
    chk("ctrl_rx_chk_en", {7'b0, rx_chk_en}, 8'h01);
    read_expect(2'd1, 8'h00, "status_idle");

    // Long rx_int pulse -> exactly one entry.
    frame(8'hA5, 1'b0, 20);
    read_expect(2'd1, 8'h01, "status_one");
    read_expect(2'd0, 8'hA5, "data_a5");
    read_expect(2'd1, 8'h00, "status_after_pop");

    // Overflow: 17 frames into 16 entries.
    for (int i = 0; i < 17; i++) frame(8'(i), 1'b0, 3);
    read_expect(2'd1, 8'h07, "status_overflow");
    for (int i = 0; i < 16; i++) read_expect(2'd0, 8'(i), "data_order");
    read_expect(2'd0, 8'h00, "data_empty");
    bus_write(2'd3, 8'h04);
    read_expect(2'd1, 8'h00, "status_ovr_cleared");

    // Threshold interrupt: THR=3, IE_DATA.
    bus_write(2'd2, 8'h34);
    for (int i = 1; i <= 3; i++) begin
      frame(8'(8'h10 + i), 1'b0, 2);
      chk("irq_below_thr", {7'b0, irq}, 8'h00);
    end
    frame(8'h14, 1'b0, 2);
    chk("irq_above_thr", {7'b0, irq}, 8'h01);
    read_expect(2'd0, 8'h11, "data_thr_pop");
    tick();
    chk("irq_after_pop", {7'b0, irq}, 8'h00);
    for (int i = 2; i <= 4; i++) read_expect(2'd0, 8'(8'h10 + i), "data_thr_drain");

    // Parity error path with IE_ERR.
    bus_write(2'd2, 8'h08);
    frame(8'h3C, 1'b1, 4);
    read_expect(2'd1, 8'h19, "status_perr");
    chk("irq_perr", {7'b0, irq}, 8'h01);
    rx_dat = 8'h5A; rx_err = 1'b1; rx_int = 1'b1;
    bus_if.bus_addr = 2'd3; bus_if.bus_wdata = 8'h08; bus_if.bus_wr = 1'b1;
    tick();
    bus_if.bus_wr = 1'b0;
    tick(2);
    rx_int = 1'b0;
    tick(2);
    read_expect(2'd1, 8'h19, "perr_set_wins");
    bus_write(2'd3, 8'h08);
    read_expect(2'd1, 8'h11, "status_perr_cleared");
    chk("irq_perr_cleared", {7'b0, irq}, 8'h00);

    // Simultaneous write and read of CTRL: read returns the old value.
    bus_if.bus_addr = 2'd2; bus_if.bus_wdata = 8'h03; bus_if.bus_wr = 1'b1; bus_if.bus_rd = 1'b1;
    tick();
    bus_if.bus_wr = 1'b0; bus_if.bus_rd = 1'b0;
    chk("ctrl_rw_old", bus_if.bus_rdata, 8'h08);
    read_expect(2'd2, 8'h03, "ctrl_readback");

    // Idle with data held, then idle while empty.
    tick(300);
`ifdef UART_RX_TIMEOUT_EN
    read_expect(2'd1, 8'h31, "status_timeout");
`else
    read_expect(2'd1, 8'h11, "status_no_timeout");
`endif
    read_expect(2'd0, 8'h3C, "data_3c");
    read_expect(2'd0, 8'h5A, "data_5a");
`ifdef UART_RX_TIMEOUT_EN
    read_expect(2'd1, 8'h20, "status_to_sticky");
`else
    read_expect(2'd1, 8'h00, "status_empty_idle");
`endif
    bus_write(2'd3, 8'h20);
    tick(300);
    read_expect(2'd1, 8'h00, "status_to_empty");

    // Full FIFO: push and pop together drops the push and sets OVR.
    for (int i = 0; i < 16; i++) frame(8'(8'h40 + i), 1'b0, 2);
    read_expect(2'd1, 8'h03, "status_full");
    rx_dat = 8'h99; rx_err = 1'b0; rx_int = 1'b1;
    bus_if.bus_addr = 2'd0; bus_if.bus_rd = 1'b1;
    tick();
    bus_if.bus_rd = 1'b0;
    chk("data_full_pushpop", bus_if.bus_rdata, 8'h40);
    rx_int = 1'b0;
    tick(2);
    read_expect(2'd1, 8'h05, "status_full_pushpop");
    bus_write(2'd3, 8'h04);
    // Not full: push and pop together keep the count.
    rx_dat = 8'h77; rx_int = 1'b1;
    bus_if.bus_addr = 2'd0; bus_if.bus_rd = 1'b1;
    tick();
    bus_if.bus_rd = 1'b0;
    chk("data_pushpop", bus_if.bus_rdata, 8'h41);
    rx_int = 1'b0;
    tick(2);
    read_expect(2'd1, 8'h01, "status_pushpop");
    read_expect(2'd0, 8'h42, "data_after_pushpop");

    // Asynchronous reset in the middle of a frame.
    rx_dat = 8'h66; rx_int = 1'b1;
    tick();
    #2 rst = 1'b1;
    tick();
    chk("arst_rdata", bus_if.bus_rdata, 8'h00);
    chk("arst_irq", {7'b0, irq}, 8'h00);
    chk("arst_rx_en", {7'b0, rx_en}, 8'h00);
    rx_int = 1'b0;
    tick(2);
    rst = 1'b0;
    tick();
    read_expect(2'd1, 8'h00, "status_after_arst");
    read_expect(2'd2, 8'h00, "ctrl_after_arst");
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
